scan_decoder: RTL and testbench

SCAN_DECODER -- requirements
Module: scan_decoder

---
 rtl/scan_decoder.sv | 111 +++++++++++
 tb/tb_scan_decoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/scan_decoder.sv
// rtl/scan_decoder.sv - one-hot channel scan decoder with auto dwell scan and manual select
// The drive, index and frame pulse are all registered from a single next-index decision.
module scan_decoder #(
  parameter int SEL_W      = 3,
  parameter int N_CH       = 8,
  parameter int DWELL      = 5,
  parameter int ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             manual,
  input  logic [SEL_W-1:0] sel_in,
  input  logic [N_CH-1:0]  ch_mask,
  output logic [N_CH-1:0]  d_out,
  output logic [SEL_W-1:0] cur_sel,
  output logic             frame_done
);

  localparam int              CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [N_CH-1:0]  IDLE     = (ACTIVE_LOW != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};

  logic [SEL_W-1:0] r_cur_sel;
  logic [CNT_W-1:0] r_cnt;
  logic [N_CH-1:0]  r_d_out;
  logic             r_frame_done;

  logic             w_up_found;
  logic [SEL_W-1:0] w_up_sel;
  logic             w_low_found;
  logic [SEL_W-1:0] w_low_sel;
  logic [SEL_W-1:0] w_next_sel;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_next_fd;
  logic             w_sel_ok;
  logic [N_CH-1:0]  w_dec;

  // Descending search so the last hit is the lowest qualifying index.
  always_comb begin
    w_up_found  = 1'b0;
    w_up_sel    = '0;
    w_low_found = 1'b0;
    w_low_sel   = '0;
    for (int j = N_CH - 1; j >= 0; j--) begin
      if (ch_mask[j]) begin
        w_low_found = 1'b1;
        w_low_sel   = SEL_W'(j);
        if (j > int'(r_cur_sel)) begin
          w_up_found = 1'b1;
          w_up_sel   = SEL_W'(j);
        end
      end
    end
  end

  always_comb begin
    w_next_sel = r_cur_sel;
    w_next_cnt = r_cnt;
    w_next_fd  = 1'b0;
    w_sel_ok   = 1'b1;
    if (manual) begin
      w_next_cnt = '0;
      if (int'(sel_in) < N_CH) begin
        w_next_sel = sel_in;
      end else begin
        w_sel_ok = 1'b0;
      end
    end else if (r_cnt != CNT_LAST) begin
      w_next_cnt = r_cnt + CNT_W'(1);
    end else begin
      w_next_cnt = '0;
      if (w_up_found) begin
        w_next_sel = w_up_sel;
      end else if (w_low_found) begin
        w_next_sel = w_low_sel;
        w_next_fd  = 1'b1;
      end
    end
  end

  always_comb begin
    w_dec = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_dec[i] = w_sel_ok && (w_next_sel == SEL_W'(i)) && ch_mask[i];
    end
  end

  // XOR with the idle pattern applies the output polarity.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cur_sel    <= '0;
      r_cnt        <= '0;
      r_d_out      <= IDLE;
      r_frame_done <= 1'b0;
    end else if (en) begin
      r_cur_sel    <= w_next_sel;
      r_cnt        <= w_next_cnt;
      r_d_out      <= w_dec ^ IDLE;
      r_frame_done <= w_next_fd;
    end else begin
      r_d_out      <= IDLE;
      r_frame_done <= 1'b0;
    end
  end

  assign d_out      = r_d_out;
  assign cur_sel    = r_cur_sel;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_scan_decoder.sv
// tb/tb_scan_decoder.sv - scoreboard bench for scan_decoder against a rule-level model
module tb_scan_decoder;
  localparam int SEL_W = 3;
  localparam int N_CH  = 8;
  localparam int DWELL = 5;

  logic             clk     = 1'b0;
  logic             reset   = 1'b0;
  logic             en      = 1'b0;
  logic             manual  = 1'b0;
  logic [SEL_W-1:0] sel_in  = '0;
  logic [N_CH-1:0]  ch_mask = '0;
  logic [N_CH-1:0]  d_out;
  logic [SEL_W-1:0] cur_sel;
  logic             frame_done;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] s;
    logic       f;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_cur  = 0;
  int   m_cnt  = 0;
  bit   stim_done = 0;

  scan_decoder #(.SEL_W(SEL_W), .N_CH(N_CH), .DWELL(DWELL), .ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .en(en), .manual(manual), .sel_in(sel_in),
    .ch_mask(ch_mask), .d_out(d_out), .cur_sel(cur_sel), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Rule-level model: the scan visits the ascending list of enabled channels.
  function automatic exp_t model(input logic e, input logic m, input int sel, input logic [7:0] mask);
    exp_t r;
    int   en_list[$];
    int   nxt;
    bit   active;
    r.f    = 1'b0;
    active = 0;
    if (e) begin
      if (m) begin
        m_cnt = 0;
        if (sel < N_CH) begin
          m_cur  = sel;
          active = mask[m_cur];
        end
      end else begin
        if (m_cnt < DWELL - 1) begin
          m_cnt++;
        end else begin
          m_cnt = 0;
          for (int i = 0; i < N_CH; i++) if (mask[i]) en_list.push_back(i);
          if (en_list.size() > 0) begin
            nxt = -1;
            foreach (en_list[k]) if (nxt < 0 && en_list[k] > m_cur) nxt = en_list[k];
            if (nxt < 0) begin
              nxt = en_list[0];
              r.f = 1'b1;
            end
            m_cur = nxt;
          end
        end
        active = mask[m_cur];
      end
    end
    r.d = active ? (8'hFF ^ (8'h01 << m_cur)) : 8'hFF;
    r.s = 3'(m_cur);
    return r;
  endfunction

  task automatic step(input logic e, input logic m, input int sel, input logic [7:0] mask);
    @(negedge clk);
    reset   = 1'b1;
    en      = e;
    manual  = m;
    sel_in  = 3'(sel);
    ch_mask = mask;
    q.push_back(model(e, m, sel, mask));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_d_out", int'(d_out), 8'hFF);
    chk("async_reset_cur_sel", int'(cur_sel), 0);
    chk("async_reset_frame_done", int'(frame_done), 0);
    m_cur = 0;
    m_cnt = 0;
    repeat (2) begin
      @(negedge clk);
      q.push_back(exp_t'{8'hFF, 3'd0, 1'b0});
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("d_out", int'(d_out), int'(e.d));
        chk("cur_sel", int'(cur_sel), int'(e.s));
        chk("frame_done", int'(frame_done), int'(e.f));
      end
    end
  end

  initial begin : stimulus
    int  guard;
    bit  r_man;
    logic [7:0] r_mask;
    do_reset();

    repeat (50) step(1, 0, 0, 8'hFF);
    repeat (60) step(1, 0, 0, 8'h1F);

    step(1, 1, 3, 8'hFF);
    step(1, 1, 7, 8'h7F);
    repeat (3) step(1, 1, 5, 8'hFF);
    repeat (12) step(1, 0, 0, 8'hFF);

    repeat (20) step(1, 0, 0, 8'h00);
    repeat (20) step(1, 0, 0, 8'h04);

    do_reset();
    guard = 0;
    while (!(m_cur == 1 && m_cnt == 2) && guard < 100) begin
      step(1, 0, 0, 8'hFF);
      guard++;
    end
    chk("reach_ch1_cnt2", guard < 100, 1);
    repeat (7) step(0, 0, 0, 8'hFF);
    repeat (10) step(1, 0, 0, 8'hFF);

    do_reset();
    guard = 0;
    while (!(m_cur == 4 && m_cnt == 2) && guard < 100) begin
      step(1, 0, 0, 8'hFF);
      guard++;
    end
    chk("reach_ch4_cnt2", guard < 100, 1);
    do_reset();
    repeat (10) step(1, 0, 0, 8'h11);

    r_man  = 0;
    r_mask = 8'hFF;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0: r_mask = 8'h00;
          1: r_mask = 8'h01 << $urandom_range(0, 7);
          default: r_mask = 8'($urandom);
        endcase
      end
      if ($urandom_range(0, 29) == 0) r_man = ~r_man;
      step($urandom_range(0, 9) != 0, r_man, int'($urandom_range(0, 7)), r_mask);
    end

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    stim_done = 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    if (!stim_done) begin
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
    end
  end

endmodule
